pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage dynamic pipeline.
//   Drives the PC hold, the IF/ID register's stall and is_branch (flush) inputs, and the ID/EX bubble.
//   Detects load-use hazards, sequences multi-cycle MUL/DIV occupancy with an FSM, and flushes on taken branches.
//   Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//   MUL_CYCLES  4   total EX occupancy of a multiply (>=1)
//   DIV_CYCLES  32  total EX occupancy of a divide (>=1)
//   CNT_W       6   width of busy down-counter; must hold max(MUL_CYCLES,DIV_CYCLES)-1
// PORTS
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous reset, active-high
//   id_rs          in   5   rs field of instruction in ID
//   id_rt          in   5   rt field of instruction in ID
//   id_uses_rs     in   1   ID instruction reads rs
//   id_uses_rt     in   1   ID instruction reads rt
//   ex_mem_read    in   1   instruction in EX is a load
//   ex_rt          in   5   load destination register in EX
//   id_mdu_start   in   1   ID instruction is MUL/DIV, issuing this cycle
//   id_mdu_is_div  in   1   qualifies id_mdu_start: 1=divide, 0=multiply
//   id_branch_taken in  1   branch/jump resolved taken in ID
//   perf_clr       in   1   synchronous clear of stall_count
//   pc_stall       out  1   1 = hold PC
//   if_id_stall    out  1   to IF/ID stall input: 0 = RUN (advance), 1 = hold
//   if_id_flush    out  1   to IF/ID is_branch input: zero IF/ID next edge
//   id_ex_bubble   out  1   1 = load NOP into ID/EX
//   mdu_busy       out  1   FSM in BUSY
//   mdu_done       out  1   registered 1-cycle pulse on BUSY->IDLE
//   stall_count    out  16  saturating count of cycles with pc_stall=1
// BEHAVIOUR
//   Reset (async): state=IDLE, cnt=0, mdu_done=0, stall_count=0.
//     All combinational outputs then evaluate to 0.
//   load_use = ex_mem_read & (ex_rt!=0) &
//     ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
//   FSM states: IDLE, BUSY.
//     IDLE -> BUSY when id_mdu_start & ~load_use & LAT>1, with LAT = id_mdu_is_div ? DIV_CYCLES : MUL_CYCLES.
//       On that edge cnt <= LAT-1. The MDU instruction itself advances to EX normally that cycle.
//     BUSY: cnt <= cnt-1 each edge. When cnt==1: state <= IDLE, mdu_done <= 1 for exactly the next cycle.
//     BUSY therefore lasts LAT-1 cycles. LAT==1 never leaves IDLE.
//     id_mdu_start while BUSY is ignored; the instruction is held in IF/ID and reissues after IDLE.
//   Outputs (combinational from state and inputs), priority high->low:
//     1. BUSY: pc_stall=1, if_id_stall=1, id_ex_bubble=1, if_id_flush=0.
//     2. load_use: pc_stall=1, if_id_stall=1, id_ex_bubble=1, if_id_flush=0.
//        A simultaneous id_branch_taken is suppressed because its operands are stale; it re-resolves next cycle.
//     3. id_branch_taken: if_id_flush=1, pc_stall=0, if_id_stall=0, id_ex_bubble=0.
//     4. else: all 0.
//   mdu_busy = (state==BUSY).
//   stall_count: perf_clr has priority and sets it to 0. Otherwise it increments when pc_stall=1 and holds at 16'hFFFF.
//   rst mid-BUSY: returns to IDLE immediately, with no mdu_done pulse.
// TESTING
//   Load r5 in EX, ID reads rs=5 -> one cycle pc_stall=if_id_stall=id_ex_bubble=1, then all 0.
//   Load to r0 in EX, ID reads rs=0 -> no stall.
//   DIV issue with DIV_CYCLES=32 -> mdu_busy high exactly 31 cycles; mdu_done pulses on cycle 32; stall_count=31.
//   MUL issue with MUL_CYCLES=4 -> 3 busy cycles; a second id_mdu_start during BUSY is ignored.
//   load_use and id_branch_taken together -> flush=0 and stall=1; next cycle, branch alone -> flush=1.
//   rst pulse at busy cycle 10 of a DIV -> outputs 0 asynchronously, no mdu_done.
//   Stall 65540 cycles -> stall_count saturates at 16'hFFFF; perf_clr -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It detects
//   load-use hazards and holds the front end while a multi-cycle MUL/DIV
//   occupies EX. Taken branches flush IF/ID. A saturating counter records
//   the number of cycles in which the PC was held.
//
//   State table
//     state | meaning
//     IDLE  | no MUL/DIV in flight; hazards and branches handled normally
//     BUSY  | MUL/DIV occupying EX; front end held, bubbles into ID/EX
//
// Ports
//   clk, rst         clock (rising edge), async active-high reset
//   id_rs, id_rt     source register fields of the ID instruction
//   id_uses_rs/rt    ID instruction actually reads rs / rt
//   ex_mem_read      EX instruction is a load
//   ex_rt            load destination register in EX
//   id_mdu_start     ID instruction is MUL/DIV and issues this cycle
//   id_mdu_is_div    1 = divide, 0 = multiply (qualifies id_mdu_start)
//   id_branch_taken  branch/jump resolved taken in ID
//   perf_clr         synchronous clear of stall_count
//   pc_stall         hold PC
//   if_id_stall      hold IF/ID (0 = advance)
//   if_id_flush      zero IF/ID on the next edge
//   id_ex_bubble     load a NOP into ID/EX
//   mdu_busy         FSM is in BUSY
//   mdu_done         one-cycle registered pulse on BUSY -> IDLE
//   stall_count      saturating count of cycles with pc_stall = 1
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic         id_uses_rs,
  input  logic         id_uses_rt,
  input  logic         ex_mem_read,
  input  logic [4:0]   ex_rt,
  input  logic         id_mdu_start,
  input  logic         id_mdu_is_div,
  input  logic         id_branch_taken,
  input  logic         perf_clr,
  output logic         pc_stall,
  output logic         if_id_stall,
  output logic         if_id_flush,
  output logic         id_ex_bubble,
  output logic         mdu_busy,
  output logic         mdu_done,
  output logic [15:0]  stall_count
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // Busy-phase length is LAT-1; the issue cycle itself advances normally.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;
  logic [CNT_W-1:0] busy_load;
  logic             start_busy;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  assign busy_load = id_mdu_is_div ? DIV_LOAD : MUL_LOAD;

  // A single-cycle unit (load value 0) never needs the BUSY phase.
  assign start_busy = (state == ST_IDLE) && id_mdu_start && !load_use &&
                      (busy_load != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mdu_done <= 1'b0;
    end else begin
      mdu_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_busy) begin
            state <= ST_BUSY;
            cnt   <= busy_load;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state    <= ST_IDLE;
            mdu_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign mdu_busy = (state == ST_BUSY);

  // A branch seen together with a load-use hazard used stale operands, so
  // it is dropped here and re-resolves once the hazard clears.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (mdu_busy || load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (id_branch_taken) begin
      if_id_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
    end else if (pc_stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
